// File: rtl/usr_pkg.sv
// Shared opcode/state types and helpers for the universal shift register.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package usr_pkg;

    localparam int MODE_W = 3;

    // Command opcodes; codes 7 and above are treated as HOLD by the datapath.
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

    // True for opcodes that move bits (and therefore honour the step count).
    function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step next value of the shift register for a given opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the step is applied.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] mode,
    input  logic              serial_in_l,
    input  logic              serial_in_r,
    output logic [WIDTH-1:0]  q_step
);

    generate
        if (WIDTH == 1) begin : g_w1
            // A one-bit register can only take the serial inputs; rotates and ASR hold.
            always_comb begin
                q_step = q;
                case (mode)
                    MODE_SHL: q_step = serial_in_l;
                    MODE_SHR: q_step = serial_in_r;
                    default:  q_step = q;
                endcase
            end
        end else begin : g_wn
            // One bit position of movement per step; non-shift opcodes pass q through.
            always_comb begin
                q_step = q;
                case (mode)
                    MODE_SHL: q_step = {q[WIDTH-2:0], serial_in_l};
                    MODE_SHR: q_step = {serial_in_r, q[WIDTH-1:1]};
                    MODE_ROL: q_step = {q[WIDTH-2:0], q[WIDTH-1]};
                    MODE_ROR: q_step = {q[0], q[WIDTH-1:1]};
                    MODE_ASR: q_step = {q[WIDTH-1], q[WIDTH-1:1]};
                    default:  q_step = q;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: load/shift/rotate with multi-step commands; optional parity via USR_PARITY_EN.
// Latency: LOAD/HOLD/count<=1 complete at the accepting edge; N-step shifts take N enabled edges.
// Backpressure: start is ignored while busy; en=0 freezes all state including done.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [CNT_W-1:0]  count,
    input  logic [WIDTH-1:0]  parallel_in,
    input  logic              serial_in_l,
    input  logic              serial_in_r,
    output logic [WIDTH-1:0]  parallel_out,
    output logic              serial_out_l,
    output logic              serial_out_r,
    output logic              busy,
    output logic              done
`ifdef USR_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    usr_state_e        state_q, state_nxt;
    logic [WIDTH-1:0]  q_r, q_nxt, step_q;
    logic [CNT_W-1:0]  rem_q, rem_nxt;
    logic [MODE_W-1:0] mode_q, mode_nxt, step_mode;
    logic              done_q, done_nxt;

    // During a multi-step command the latched opcode drives the datapath,
    // otherwise the incoming opcode does (used only on acceptance).
    assign step_mode = (state_q == SHIFT) ? mode_q : mode;

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q           (q_r),
        .mode        (step_mode),
        .serial_in_l (serial_in_l),
        .serial_in_r (serial_in_r),
        .q_step      (step_q)
    );

    // Next-state, register and counter update; nothing moves while en is low.
    always_comb begin
        state_nxt = state_q;
        q_nxt     = q_r;
        rem_nxt   = rem_q;
        mode_nxt  = mode_q;
        done_nxt  = done_q;
        if (en) begin
            done_nxt = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_LOAD) begin
                            q_nxt    = parallel_in;
                            done_nxt = 1'b1;
                        end else if (is_shift_mode(mode) && (count != '0)) begin
                            // First step happens on the accepting edge.
                            q_nxt = step_q;
                            if (count == CNT_W'(1)) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = SHIFT;
                                rem_nxt   = count - CNT_W'(1);
                                mode_nxt  = mode;
                            end
                        end else begin
                            // HOLD, unused opcodes and zero-count shifts complete immediately.
                            done_nxt = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    q_nxt   = step_q;
                    rem_nxt = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset aborts any shift silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_r     <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            q_r     <= q_nxt;
            rem_q   <= rem_nxt;
            mode_q  <= mode_nxt;
            done_q  <= done_nxt;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity is computed from the next value so it lines up with parallel_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_nxt;
        end
    end

    assign parity_out = parity_q;
`endif

    assign parallel_out = q_r;
    assign serial_out_l = q_r[WIDTH-1];
    assign serial_out_r = q_r[0];
    assign busy         = (state_q == SHIFT);
    assign done         = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n, en, start, serial_in_l, serial_in_r;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  parallel_in, parallel_out;
    logic          serial_out_l, serial_out_r, busy, done;
`ifdef USR_PARITY_EN
    logic          parity_out;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [W-1:0] m_q;
    logic         m_busy, m_done;
    int           m_rem;
    logic [2:0]   m_mode;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .start        (start),
        .mode         (mode),
        .count        (count),
        .parallel_in  (parallel_in),
        .serial_in_l  (serial_in_l),
        .serial_in_r  (serial_in_r),
        .parallel_out (parallel_out),
        .serial_out_l (serial_out_l),
        .serial_out_r (serial_out_r),
        .busy         (busy),
        .done         (done)
`ifdef USR_PARITY_EN
        ,
        .parity_out   (parity_out)
`endif
    );

    function automatic logic [W-1:0] ref_step(input logic [W-1:0] q, input logic [2:0] md,
                                              input logic sl, input logic sr);
        logic [W-1:0] top;
        top = '0;
        top[W-1] = sr;
        case (md)
            3'd2:    return (q << 1) | W'(sl);
            3'd3:    return (q >> 1) | top;
            3'd4:    return (q << 1) | (q >> (W - 1));
            3'd5:    return (q >> 1) | (q << (W - 1));
            3'd6:    return W'($signed(q) >>> 1);
            default: return q;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model with the currently driven inputs, push the expectation,
    // clock the DUT, then pop and compare after the edge.
    task automatic tick(input string tag);
        exp_t e;
        if (!rst_n) begin
            m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
        end else if (en) begin
            m_done = 1'b0;
            if (m_busy) begin
                m_q = ref_step(m_q, m_mode, serial_in_l, serial_in_r);
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (mode == 3'd1) begin
                    m_q = parallel_in;
                    m_done = 1'b1;
                end else if (mode >= 3'd2 && mode <= 3'd6 && count != 0) begin
                    m_q = ref_step(m_q, mode, serial_in_l, serial_in_r);
                    m_rem = int'(count) - 1;
                    if (m_rem == 0) m_done = 1'b1;
                    else begin
                        m_busy = 1'b1;
                        m_mode = mode;
                    end
                end else begin
                    m_done = 1'b1;
                end
            end
        end
        e.q = m_q; e.busy = m_busy; e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".q"},    64'(parallel_out), 64'(e.q));
        chk({tag, ".busy"}, 64'(busy),         64'(e.busy));
        chk({tag, ".done"}, 64'(done),         64'(e.done));
        chk({tag, ".sol"},  64'(serial_out_l), 64'(e.q[W-1]));
        chk({tag, ".sor"},  64'(serial_out_r), 64'(e.q[0]));
`ifdef USR_PARITY_EN
        chk({tag, ".par"},  64'(parity_out),   64'(^e.q));
`endif
    endtask

    task automatic cmd(input logic [2:0] md, input logic [CW-1:0] n, input logic [W-1:0] pin,
                       input string tag);
        start = 1'b1; mode = md; count = n; parallel_in = pin;
        tick(tag);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; start = 1'b1; mode = 3'd1; count = '0;
        parallel_in = 8'hFF; serial_in_l = 1'b0; serial_in_r = 1'b0;

        // Reset overrides a pending start
        tick("reset0");
        start = 1'b0;
        tick("reset1");
        chk("reset_q", 64'(parallel_out), 64'h0);
        rst_n = 1'b1;

        // 1: LOAD A5, one-cycle done, no busy
        cmd(3'd1, 0, 8'hA5, "load_a5");
        chk("load_a5_val", 64'(parallel_out), 64'hA5);
        tick("load_a5_idle");

        // 2: ROL x3 from 81 -> 0C
        cmd(3'd1, 0, 8'h81, "load_81");
        cmd(3'd4, 3, 8'h00, "rol3_e0");
        tick("rol3_s1");
        tick("rol3_s2");
        chk("rol3_val", 64'(parallel_out), 64'h0C);
        tick("rol3_idle");

        // 3: ASR x2 from 90 -> E4; SHR x1 from 01 with serial_in_r=1 -> 80
        cmd(3'd1, 0, 8'h90, "load_90");
        cmd(3'd6, 2, 8'h00, "asr2_e0");
        tick("asr2_s1");
        chk("asr2_val", 64'(parallel_out), 64'hE4);
        cmd(3'd1, 0, 8'h01, "load_01");
        serial_in_r = 1'b1;
        cmd(3'd3, 1, 8'h00, "shr1_e0");
        serial_in_r = 1'b0;
        chk("shr1_val", 64'(parallel_out), 64'h80);

        // 4: start while busy ignored; en low for two cycles mid-shift
        cmd(3'd1, 0, 8'h3C, "load_3c");
        cmd(3'd4, 4, 8'h00, "rol4_e0");
        cmd(3'd1, 0, 8'hFF, "rol4_ignored_load");
        en = 1'b0;
        tick("rol4_stall0");
        tick("rol4_stall1");
        en = 1'b1;
        tick("rol4_s2");
        tick("rol4_s3");
        chk("rol4_val", 64'(parallel_out), 64'hC3);
        tick("rol4_idle");

        // 5: reset in the middle of a 5-step SHL
        cmd(3'd1, 0, 8'hFF, "load_ff");
        serial_in_l = 1'b1;
        cmd(3'd2, 5, 8'h00, "shl5_e0");
        tick("shl5_s1");
        rst_n = 1'b0;
        tick("shl5_reset");
        chk("shl5_rst_q", 64'(parallel_out), 64'h0);
        rst_n = 1'b1;
        tick("shl5_after");
        serial_in_l = 1'b0;

        // 6: zero-count shift, unused opcode, count beyond width
        cmd(3'd1, 0, 8'h5A, "load_5a");
        cmd(3'd2, 0, 8'h00, "shl0");
        chk("shl0_val", 64'(parallel_out), 64'h5A);
        cmd(3'd7, 3, 8'h00, "op7");
        cmd(3'd1, 0, 8'h81, "load_81b");
        cmd(3'd4, 9, 8'h00, "rol9_e0");
        for (int i = 1; i < 9; i++) tick("rol9_s");
        chk("rol9_val", 64'(parallel_out), 64'h03);

        // Random mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            en          = ($urandom_range(0, 4) != 0);
            start       = $urandom_range(0, 1);
            mode        = 3'($urandom_range(0, 7));
            count       = CW'($urandom_range(0, 12));
            parallel_in = W'($urandom);
            serial_in_l = $urandom_range(0, 1);
            serial_in_r = $urandom_range(0, 1);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
